// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: buffers retiring instructions in a FWFT FIFO
// and streams stamped records over a valid/ready link to the checker.
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CYC_W = 32,
    parameter int SEQ_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [15:0]                wb_pc,
    input  logic                       wb_regwrite,
    input  logic [3:0]                 wb_rd,
    input  logic [15:0]                wb_data,
    input  logic                       wb_hlt,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [15:0]                trace_pc,
    output logic                       trace_we,
    output logic [3:0]                 trace_rd,
    output logic [15:0]                trace_data,
    output logic                       trace_hlt,
    output logic [SEQ_W-1:0]           trace_seq,
    output logic [CYC_W-1:0]           trace_cycle,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [15:0]      pc;
        logic             we;
        logic [3:0]       rd;
        logic [15:0]      data;
        logic             hlt;
        logic [SEQ_W-1:0] seq;
        logic [CYC_W-1:0] cyc;
    } rec_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTED,
        S_DONE
    } state_t;

    state_t           state;
    rec_t             mem [DEPTH];
    rec_t             new_rec;
    rec_t             head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    fill_q;
    logic [LW-1:0]    fill_nxt;
    logic [CYC_W-1:0] cycle_cnt;
    logic [SEQ_W-1:0] seq_cnt;
    logic             empty;
    logic             full;
    logic             commit;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty  = (fill_q == '0);
    assign full   = (fill_q == LW'(DEPTH));
    assign commit = wb_valid && (state == S_RUN);
    assign pop    = !empty && trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push   = commit && (!full || pop);
    assign drop   = commit && full && !pop;

    always_comb begin
        new_rec      = '0;
        new_rec.pc   = wb_pc;
        new_rec.we   = wb_regwrite;
        new_rec.rd   = wb_regwrite ? wb_rd : 4'd0;
        new_rec.data = wb_regwrite ? wb_data : 16'd0;
        new_rec.hlt  = wb_hlt;
        new_rec.seq  = seq_cnt;
        new_rec.cyc  = cycle_cnt;
    end

    always_comb begin
        fill_nxt = fill_q;
        unique case ({push, pop})
            2'b10:   fill_nxt = fill_q + 1'b1;
            2'b01:   fill_nxt = fill_q - 1'b1;
            default: fill_nxt = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill_q    <= '0;
            cycle_cnt <= '0;
            seq_cnt   <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            state     <= S_RUN;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            fill_q    <= fill_nxt;
            if (commit) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                S_RUN: begin
                    if (push && wb_hlt) begin
                        state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (fill_nxt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    // Head is masked so every trace field reads 0 while the FIFO is empty.
    assign head        = empty ? '0 : mem[rd_ptr];
    assign trace_valid = !empty;
    assign trace_pc    = head.pc;
    assign trace_we    = head.we;
    assign trace_rd    = head.rd;
    assign trace_data  = head.data;
    assign trace_hlt   = head.hlt;
    assign trace_seq   = head.seq;
    assign trace_cycle = head.cyc;
    assign fill_level  = fill_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Scoreboard bench for commit_trace_tx: stimulus queues expected records,
// a negedge monitor compares each accepted head against the queue.
module tb_commit_trace_tx;

    typedef struct {
        logic [15:0] pc;
        logic        we;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        hlt;
        logic [15:0] seq;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [15:0] wb_pc;
    logic        wb_regwrite;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_hlt;
    logic        trace_valid;
    logic        trace_ready;
    logic [15:0] trace_pc;
    logic        trace_we;
    logic [3:0]  trace_rd;
    logic [15:0] trace_data;
    logic        trace_hlt;
    logic [15:0] trace_seq;
    logic [31:0] trace_cycle;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        done;

    exp_t        q[$];
    int          passed;
    int          total;
    logic [15:0] exp_seq;
    logic [31:0] cyc;

    commit_trace_tx #(.DEPTH(8), .CYC_W(32), .SEQ_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .wb_valid(wb_valid),
        .wb_pc(wb_pc),
        .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .wb_hlt(wb_hlt),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_pc(trace_pc),
        .trace_we(trace_we),
        .trace_rd(trace_rd),
        .trace_data(trace_data),
        .trace_hlt(trace_hlt),
        .trace_seq(trace_seq),
        .trace_cycle(trace_cycle),
        .fill_level(fill_level),
        .overflow(overflow),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles elapsed since reset release, used for the cycle stamp.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    always @(negedge clk) begin
        if (!rst && trace_valid && trace_ready) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_record: got pc=%h seq=%0d, required none",
                         trace_pc, trace_seq);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (trace_pc !== e.pc || trace_we !== e.we || trace_rd !== e.rd ||
                    trace_data !== e.data || trace_hlt !== e.hlt ||
                    trace_seq !== e.seq || trace_cycle !== e.cyc) begin
                    $display("FAIL record: got pc=%h we=%b rd=%0d data=%h hlt=%b seq=%0d cyc=%0d, required pc=%h we=%b rd=%0d data=%h hlt=%b seq=%0d cyc=%0d",
                             trace_pc, trace_we, trace_rd, trace_data, trace_hlt,
                             trace_seq, trace_cycle, e.pc, e.we, e.rd, e.data,
                             e.hlt, e.seq, e.cyc);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        else
            passed++;
    endtask

    // Called just after a posedge; returns just after the capture posedge.
    task automatic commit(input logic [15:0] pc, input logic we,
                          input logic [3:0] rd, input logic [15:0] data,
                          input logic hlt, input bit acc, input bit adv,
                          input int cyc_req);
        exp_t e;
        wb_valid    = 1'b1;
        wb_pc       = pc;
        wb_regwrite = we;
        wb_rd       = rd;
        wb_data     = data;
        wb_hlt      = hlt;
        if (acc) begin
            e.pc   = pc;
            e.we   = we;
            e.rd   = we ? rd : 4'd0;
            e.data = we ? data : 16'd0;
            e.hlt  = hlt;
            e.seq  = exp_seq;
            e.cyc  = (cyc_req < 0) ? cyc : 32'(cyc_req);
            q.push_back(e);
        end
        if (adv) exp_seq++;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        wb_hlt   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        exp_seq = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        exp_seq     = 16'd0;
        rst         = 1'b1;
        wb_valid    = 1'b0;
        wb_pc       = 16'd0;
        wb_regwrite = 1'b0;
        wb_rd       = 4'd0;
        wb_data     = 16'd0;
        wb_hlt      = 1'b0;
        trace_ready = 1'b0;

        // Reset state and first cycle stamp
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        idle(3);
        trace_ready = 1'b1;
        commit(16'h0100, 1'b0, 4'd7, 16'h1234, 1'b0, 1, 1, 3);
        idle(3);
        @(negedge clk);
        chk("t1_drain", 64'(fill_level), 64'd0);
        idle(1);

        // Stream with ready held high
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            commit(16'(2 * i), 1'b1, 4'(i + 1), 16'(16'hA0 + i), 1'b0, 1, 1, -1);
        idle(3);
        @(negedge clk);
        chk("t2_drain", 64'(fill_level), 64'd0);
        idle(1);

        // Backpressure, overflow and seq gap
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            commit(16'(16'h0200 + 2 * i), 1'b1, 4'(i), 16'(16'h0B00 + i), 1'b0, 1, 1, -1);
        commit(16'h0210, 1'b1, 4'd9, 16'h0BFF, 1'b0, 0, 1, -1);
        @(negedge clk);
        chk("t3_fill", 64'(fill_level), 64'd8);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_head_seq", 64'(trace_seq), 64'd0);
        idle(1);
        trace_ready = 1'b1;
        idle(9);
        commit(16'h0300, 1'b1, 4'd3, 16'h0C00, 1'b0, 1, 1, -1);
        idle(3);
        @(negedge clk);
        chk("t3_drain", 64'(fill_level), 64'd0);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);
        idle(1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            commit(16'(16'h0400 + 2 * i), 1'b0, 4'd0, 16'd0, 1'b0, 1, 1, -1);
        trace_ready = 1'b1;
        commit(16'h0410, 1'b1, 4'd15, 16'hBEEF, 1'b0, 1, 1, -1);
        @(negedge clk);
        chk("t4_fill", 64'(fill_level), 64'd8);
        chk("t4_overflow", 64'(overflow), 64'd0);
        idle(10);
        @(negedge clk);
        chk("t4_drain", 64'(fill_level), 64'd0);
        idle(1);
        trace_ready = 1'b0;

        // HLT, stray commit, done
        do_reset();
        commit(16'h0010, 1'b1, 4'd2, 16'h0042, 1'b0, 1, 1, -1);
        commit(16'h0012, 1'b0, 4'd0, 16'd0, 1'b1, 1, 1, -1);
        commit(16'h0014, 1'b1, 4'd3, 16'h0099, 1'b0, 0, 0, -1);
        @(negedge clk);
        chk("t5_fill", 64'(fill_level), 64'd2);
        chk("t5_done_early", 64'(done), 64'd0);
        idle(1);
        trace_ready = 1'b1;
        @(negedge clk);
        chk("t5_done_first", 64'(done), 64'd0);
        idle(1);
        @(negedge clk);
        chk("t5_head_hlt", 64'(trace_hlt), 64'd1);
        chk("t5_done_hlt", 64'(done), 64'd0);
        idle(1);
        @(negedge clk);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_valid", 64'(trace_valid), 64'd0);
        idle(1);
        commit(16'h0016, 1'b1, 4'd4, 16'h0077, 1'b0, 0, 0, -1);
        @(negedge clk);
        chk("t5_post_fill", 64'(fill_level), 64'd0);
        chk("t5_post_done", 64'(done), 64'd1);
        idle(1);
        trace_ready = 1'b0;

        // Mid-run asynchronous reset
        do_reset();
        for (int i = 0; i < 4; i++)
            commit(16'(16'h0500 + 2 * i), 1'b1, 4'(i + 1), 16'(16'h0D00 + i), 1'b0, 1, 1, -1);
        @(negedge clk);
        chk("t6_fill", 64'(fill_level), 64'd4);
        chk("t6_valid_pre", 64'(trace_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 64'(trace_valid), 64'd0);
        chk("t6_fill_async", 64'(fill_level), 64'd0);
        q.delete();
        exp_seq = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        trace_ready = 1'b1;
        commit(16'h0600, 1'b1, 4'd6, 16'h0E00, 1'b0, 1, 1, -1);
        idle(3);
        @(negedge clk);
        chk("t6_drain", 64'(fill_level), 64'd0);

        chk("leftover", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
